fir_sched: RTL and testbench

- Cycle-level scheduler for the complex symmetric 29-tap FIR datapath (15 coefficient pairs, 5 multiplier blocks time-shared over 3 groups).
- Issues the input-FIFO pull that shifts one sample into the delay line.
- Steps the multiplier group select, and tracks the 2-stage multiplier latency to generate partial-accumulate and final-rounding strobes.
- Arbitrates coefficient writes against an in-flight computation, so each output uses one consistent coefficient set.

---
 rtl/fir_sched_pkg.sv | 24 ++
 rtl/fir_sched_vpipe.sv | 39 +++
 rtl/fir_sched.sv | 117 +++++++++++
 tb/tb_fir_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared constants and types for the FIR cycle scheduler.
//   NUM_TAPS / NUM_COEF / NUM_MULT describe the complex symmetric FIR:
//   29 taps fold into 15 coefficient pairs, served by 5 multiplier blocks.
//   NGROUPS is the number of multiplier passes needed per output sample.
//   sched_state_t is the scheduler state encoding.
package fir_sched_pkg;

  localparam int NUM_TAPS = 29;
  localparam int NUM_COEF = 15;
  localparam int NUM_MULT = 5;
  localparam int NGROUPS  = NUM_COEF / NUM_MULT;
  localparam int MULT_LAT = 2;
  localparam int SEL_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    COEF,
    PULL,
    MULT,
    DRAIN,
    ROUND
  } sched_state_t;

endpackage

// File: rtl/fir_sched_vpipe.sv
// fir_sched_vpipe: DEPTH-deep valid shift register that delays the
// multiplier issue bit by the multiplier pipeline latency.
// Ports:
//   clk      in  rising-edge clock
//   i_clr_n  in  synchronous active-low clear (empties the pipe)
//   i_issue  in  a group is being issued to the multipliers this cycle
//   o_valid  out issue bit delayed by DEPTH cycles
module fir_sched_vpipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_clr_n,
  input  logic i_issue,
  output logic o_valid
);

  logic [DEPTH-1:0] r_shift;
  logic [DEPTH-1:0] w_shift_in;

  assign w_shift_in[0] = i_issue;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign w_shift_in[gi] = r_shift[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_in;
    end
  end

  assign o_valid = r_shift[DEPTH-1];

endmodule

// File: rtl/fir_sched.sv
// fir_sched: cycle-level scheduler for the time-shared symmetric FIR.
// One output takes PULL (1) + MULT (NGROUPS) + DRAIN (MULT_LAT) + ROUND (1)
// cycles. Coefficient writes are only granted between computations so each
// output sees one consistent coefficient set.
// Ports:
//   clk            in  rising-edge clock
//   Reset          in  synchronous active-low reset
//   fifo_empty     in  input sample FIFO is empty
//   PushCoef       in  coefficient write request (held until granted)
//   fifo_pull      out pop FIFO head / shift delay line
//   CoefStall      out coefficient write refused (computation in flight)
//   coef_we        out coefficient write granted
//   mux_sel        out multiplier group select (0 outside MULT)
//   pp_acc_valid   out multiplier result valid, accumulate it
//   final_round_en out all groups accumulated, round and emit
//   busy           out computation in flight
module fir_sched #(
  parameter int NGROUPS  = fir_sched_pkg::NGROUPS,
  parameter int MULT_LAT = fir_sched_pkg::MULT_LAT,
  parameter int SEL_W    = fir_sched_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             fifo_empty,
  input  logic             PushCoef,
  output logic             fifo_pull,
  output logic             CoefStall,
  output logic             coef_we,
  output logic [SEL_W-1:0] mux_sel,
  output logic             pp_acc_valid,
  output logic             final_round_en,
  output logic             busy
);

  import fir_sched_pkg::*;

  localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cnt_next;
  logic [DW-1:0]    r_drain;
  logic [DW-1:0]    w_drain_next;
  logic             w_issue;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_drain_next = r_drain;
    case (r_state)
      // IDLE, COEF (once the request drops) and ROUND share the same
      // dispatch: coefficient writes win over a waiting sample.
      IDLE, COEF, ROUND: begin
        if (PushCoef)         w_state_next = COEF;
        else if (!fifo_empty) w_state_next = PULL;
        else                  w_state_next = IDLE;
      end
      PULL: begin
        w_state_next = MULT;
        w_cnt_next   = '0;
      end
      MULT: begin
        if (r_cnt == SEL_W'(NGROUPS - 1)) begin
          w_state_next = DRAIN;
          w_cnt_next   = '0;
          w_drain_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == DW'(MULT_LAT - 1)) begin
          w_state_next = ROUND;
          w_drain_next = '0;
        end else begin
          w_drain_next = r_drain + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy           = (r_state == PULL) || (r_state == MULT) ||
                          (r_state == DRAIN) || (r_state == ROUND);
  // PULL is only entered with a non-empty FIFO; the gate keeps a pop from
  // ever reaching an empty FIFO even if the flag misbehaves.
  assign fifo_pull      = (r_state == PULL) && !fifo_empty;
  assign coef_we        = (r_state == COEF) && PushCoef;
  assign CoefStall      = PushCoef && busy;
  assign mux_sel        = (r_state == MULT) ? r_cnt : '0;
  assign final_round_en = (r_state == ROUND);
  assign w_issue        = (r_state == MULT);

  // Cleared by reset so an aborted computation leaves no stray results.
  fir_sched_vpipe #(
    .DEPTH(MULT_LAT)
  ) u_vpipe (
    .clk    (clk),
    .i_clr_n(Reset),
    .i_issue(w_issue),
    .o_valid(pp_acc_valid)
  );

endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: scoreboard bench for fir_sched. Each cycle the stimulus
// pushes the expected outputs of both DUT instances (default parameters and
// NGROUPS=4/MULT_LAT=3) and the monitor pops and compares them.
module tb_fir_sched;

  typedef struct packed {
    logic       pull;
    logic       stall;
    logic       we;
    logic [1:0] sel;
    logic       pp;
    logic       fin;
    logic       busy;
  } exp_t;

  localparam exp_t X_IDLE = '0;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       PushCoef = 1'b0;
  logic       fifo_empty2 = 1'b1;
  logic       push_coef2 = 1'b0;

  logic       fifo_pull, CoefStall, coef_we, pp_acc_valid, final_round_en, busy;
  logic [1:0] mux_sel;
  logic       fifo_pull2, coef_stall2, coef_we2, pp_acc_valid2, final_round_en2, busy2;
  logic [1:0] mux_sel2;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_outputs = 0;
  int   cyc_no = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  fir_sched u_dut (
    .clk           (clk),
    .Reset         (Reset),
    .fifo_empty    (fifo_empty),
    .PushCoef      (PushCoef),
    .fifo_pull     (fifo_pull),
    .CoefStall     (CoefStall),
    .coef_we       (coef_we),
    .mux_sel       (mux_sel),
    .pp_acc_valid  (pp_acc_valid),
    .final_round_en(final_round_en),
    .busy          (busy)
  );

  fir_sched #(
    .NGROUPS (4),
    .MULT_LAT(3),
    .SEL_W   (2)
  ) u_dut2 (
    .clk           (clk),
    .Reset         (Reset),
    .fifo_empty    (fifo_empty2),
    .PushCoef      (push_coef2),
    .fifo_pull     (fifo_pull2),
    .CoefStall     (coef_stall2),
    .coef_we       (coef_we2),
    .mux_sel       (mux_sel2),
    .pp_acc_valid  (pp_acc_valid2),
    .final_round_en(final_round_en2),
    .busy          (busy2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_no, got, exp);
    end
  endtask

  task automatic compare(input string who, input exp_t got, input exp_t e);
    check({who, ".fifo_pull"},      32'(got.pull),  32'(e.pull));
    check({who, ".CoefStall"},      32'(got.stall), 32'(e.stall));
    check({who, ".coef_we"},        32'(got.we),    32'(e.we));
    check({who, ".mux_sel"},        32'(got.sel),   32'(e.sel));
    check({who, ".pp_acc_valid"},   32'(got.pp),    32'(e.pp));
    check({who, ".final_round_en"}, 32'(got.fin),   32'(e.fin));
    check({who, ".busy"},           32'(got.busy),  32'(e.busy));
  endtask

  // Expected outputs at offset o from the PULL cycle of one computation.
  function automatic exp_t exp_comp(input int o, input int n, input int l, input logic push);
    exp_t e;
    e       = '0;
    e.pull  = (o == 0);
    e.sel   = (o >= 1 && o <= n) ? 2'(o - 1) : 2'd0;
    e.pp    = (o >= l + 1 && o <= l + n);
    e.fin   = (o == n + l + 1);
    e.busy  = 1'b1;
    e.stall = push;
    return e;
  endfunction

  function automatic exp_t exp_coef(input logic push);
    exp_t e;
    e    = '0;
    e.we = push;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge, record expectations,
  // then compare both DUTs on the falling edge.
  task automatic cyc(input logic rst_n, input logic emp, input logic push, input exp_t x1,
                     input logic emp2, input exp_t x2);
    exp_t e1, e2, g1, g2;
    @(posedge clk);
    #1;
    Reset       = rst_n;
    fifo_empty  = emp;
    PushCoef    = push;
    fifo_empty2 = emp2;
    q1.push_back(x1);
    q2.push_back(x2);
    @(negedge clk);
    cyc_no++;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    g1 = '{fifo_pull, CoefStall, coef_we, mux_sel, pp_acc_valid, final_round_en, busy};
    g2 = '{fifo_pull2, coef_stall2, coef_we2, mux_sel2, pp_acc_valid2, final_round_en2, busy2};
    compare("dut", g1, e1);
    compare("dut2", g2, e2);
    if (final_round_en || final_round_en2) begin
      n_outputs++;
      $display("tb: output %0d emitted at cycle %0d (dut=%0b dut2=%0b)",
               n_outputs, cyc_no, final_round_en, final_round_en2);
    end
  endtask

  task automatic step(input logic rst_n, input logic emp, input logic push, input exp_t x1);
    cyc(rst_n, emp, push, x1, 1'b1, X_IDLE);
  endtask

  task automatic single_sample();
    step(1'b1, 1'b0, 1'b0, X_IDLE);
    for (int o = 0; o <= 6; o++)
      step(1'b1, (o == 0) ? 1'b0 : 1'b1, 1'b0, exp_comp(o, 3, 2, 1'b0));
    step(1'b1, 1'b1, 1'b0, X_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a pending sample and coefficient request.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, X_IDLE);
    step(1'b1, 1'b0, 1'b1, X_IDLE);
    step(1'b1, 1'b0, 1'b1, exp_coef(1'b1));
    step(1'b1, 1'b0, 1'b1, exp_coef(1'b1));
    step(1'b1, 1'b1, 1'b0, exp_coef(1'b0));
    step(1'b1, 1'b1, 1'b0, X_IDLE);

    single_sample();

    // Four back-to-back samples: pulls at offsets 0, 7, 14, 21.
    step(1'b1, 1'b0, 1'b0, X_IDLE);
    for (int o = 0; o < 28; o++)
      step(1'b1, (o <= 21) ? 1'b0 : 1'b1, 1'b0, exp_comp(o % 7, 3, 2, 1'b0));
    step(1'b1, 1'b1, 1'b0, X_IDLE);

    // Coefficient request arriving mid-computation, held past ROUND.
    step(1'b1, 1'b0, 1'b0, X_IDLE);
    for (int o = 0; o <= 6; o++)
      step(1'b1, 1'b0, (o >= 2), exp_comp(o, 3, 2, (o >= 2)));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, exp_coef(1'b1));
    step(1'b1, 1'b0, 1'b0, exp_coef(1'b0));
    for (int o = 0; o <= 6; o++)
      step(1'b1, (o == 0) ? 1'b0 : 1'b1, 1'b0, exp_comp(o, 3, 2, 1'b0));
    step(1'b1, 1'b1, 1'b0, X_IDLE);

    // Reset during DRAIN aborts the computation without a final strobe.
    step(1'b1, 1'b0, 1'b0, X_IDLE);
    for (int o = 0; o <= 4; o++)
      step((o == 4) ? 1'b0 : 1'b1, (o == 0) ? 1'b0 : 1'b1, 1'b0, exp_comp(o, 3, 2, 1'b0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, X_IDLE);
    single_sample();

    // Second instance: NGROUPS=4, MULT_LAT=3, two back-to-back samples.
    cyc(1'b1, 1'b1, 1'b0, X_IDLE, 1'b0, X_IDLE);
    for (int o = 0; o < 18; o++)
      cyc(1'b1, 1'b1, 1'b0, X_IDLE, (o <= 9) ? 1'b0 : 1'b1, exp_comp(o % 9, 4, 3, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, X_IDLE, 1'b1, X_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
